method_sprite_blit: RTL and testbench

Pixel-pipeline stage that sits directly upstream of the 90×90 RGB565 "method" image ROM and consumes its output. It tracks the display scan position, generates the ROM read address for pixels inside a movable sprite window, and waits out the ROM read latency. It then overlays the returned pixel on the incoming background pixel, with hsync/vsync/de delayed to match, for the LCD/VGA output block.

---
 rtl/method_sprite_blit.sv | 159 +++++++++++++++
 tb/tb_method_sprite_blit.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/method_sprite_blit.sv
// Sprite overlay stage for the 90x90 RGB565 method ROM: window test, ROM addressing, 2-clock aligned compositing.
// Optional colour keying is enabled by defining METHOD_SPRITE_KEY_EN.
module method_sprite_blit #(
    parameter int unsigned SPR_W     = 90,
    parameter int unsigned SPR_H     = 90,
    parameter int unsigned ADDR_W    = 13,
    parameter logic [15:0] KEY_COLOR = 16'hF81F
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              frame_start_i,
    input  logic [9:0]        pix_x_i,
    input  logic [9:0]        pix_y_i,
    input  logic              de_in_i,
    input  logic              hs_in_i,
    input  logic              vs_in_i,
    input  logic [15:0]       bg_rgb_i,
    input  logic [9:0]        spr_x_i,
    input  logic [9:0]        spr_y_i,
    input  logic              spr_show_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [15:0]       rom_data_i,
    output logic [15:0]       rgb_out_o,
    output logic              de_out_o,
    output logic              hs_out_o,
    output logic              vs_out_o
);

`ifdef METHOD_SPRITE_KEY_EN
    localparam logic KEY_EN = 1'b1;
`else
    localparam logic KEY_EN = 1'b0;
`endif

    localparam logic [10:0]       SPR_W11  = 11'(SPR_W);
    localparam logic [10:0]       SPR_H11  = 11'(SPR_H);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SPR_W);
    localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(SPR_W * (SPR_H - 1));

    logic [9:0]        pos_x_q, pos_x_d;
    logic [9:0]        pos_y_q, pos_y_d;
    logic              show_q, show_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              row_hit_q, row_hit_d;
    logic              in_win_s1_q, in_win_s2_q;
    logic [15:0]       bg_s1_q, bg_s2_q;
    logic              de_s1_q, de_s2_q, hs_s1_q, hs_s2_q, vs_s1_q, vs_s2_q;
    logic [15:0]       rgb_q, rgb_d;
    logic              de_out_q, hs_out_q, vs_out_q;

    logic [10:0]       px_s, py_s, pos_x11_s, pos_y11_s, col_s;
    logic              row_in_s, col_in_s, in_win_s, de_fall_s, key_hit_s;

    // Stage 0: window test, ROM address and per-line row base bookkeeping.
    always_comb begin
        px_s      = {1'b0, pix_x_i};
        py_s      = {1'b0, pix_y_i};
        pos_x11_s = {1'b0, pos_x_q};
        pos_y11_s = {1'b0, pos_y_q};
        row_in_s  = (py_s >= pos_y11_s) && (py_s < (pos_y11_s + SPR_H11));
        col_in_s  = (px_s >= pos_x11_s) && (px_s < (pos_x11_s + SPR_W11));
        in_win_s  = show_q & de_in_i & row_in_s & col_in_s;
        col_s     = px_s - pos_x11_s;
        de_fall_s = de_s1_q & ~de_in_i;
        key_hit_s = KEY_EN & (rom_data_i == KEY_COLOR);

        if (frame_start_i) begin
            pos_x_d = spr_x_i;
            pos_y_d = spr_y_i;
            show_d  = spr_show_i;
        end else begin
            pos_x_d = pos_x_q;
            pos_y_d = pos_y_q;
            show_d  = show_q;
        end

        if (in_win_s) begin
            rom_addr_d = row_base_q + ADDR_W'(col_s);
        end else begin
            rom_addr_d = rom_addr_q;
        end

        // row_hit remembers whether the most recent active pixel lay on a sprite row
        if (de_in_i) begin
            row_hit_d = row_in_s;
        end else begin
            row_hit_d = row_hit_q;
        end

        if (frame_start_i) begin
            row_base_d = {ADDR_W{1'b0}};
        end else if (de_fall_s && row_hit_q && (row_base_q < ROW_LAST)) begin
            row_base_d = row_base_q + ROW_STEP;
        end else begin
            row_base_d = row_base_q;
        end

        if (in_win_s2_q && !key_hit_s) begin
            rgb_d = rom_data_i;
        end else begin
            rgb_d = bg_s2_q;
        end
    end

    // Pipeline registers: stage 0 address, stage 1 ROM wait, stage 2 composite output.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pos_x_q     <= 10'd0;
            pos_y_q     <= 10'd0;
            show_q      <= 1'b0;
            row_base_q  <= {ADDR_W{1'b0}};
            rom_addr_q  <= {ADDR_W{1'b0}};
            row_hit_q   <= 1'b0;
            in_win_s1_q <= 1'b0;
            in_win_s2_q <= 1'b0;
            bg_s1_q     <= 16'h0000;
            bg_s2_q     <= 16'h0000;
            de_s1_q     <= 1'b0;
            de_s2_q     <= 1'b0;
            hs_s1_q     <= 1'b0;
            hs_s2_q     <= 1'b0;
            vs_s1_q     <= 1'b0;
            vs_s2_q     <= 1'b0;
            rgb_q       <= 16'h0000;
            de_out_q    <= 1'b0;
            hs_out_q    <= 1'b0;
            vs_out_q    <= 1'b0;
        end else begin
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            show_q      <= show_d;
            row_base_q  <= row_base_d;
            rom_addr_q  <= rom_addr_d;
            row_hit_q   <= row_hit_d;
            in_win_s1_q <= in_win_s;
            in_win_s2_q <= in_win_s1_q;
            bg_s1_q     <= bg_rgb_i;
            bg_s2_q     <= bg_s1_q;
            de_s1_q     <= de_in_i;
            de_s2_q     <= de_s1_q;
            hs_s1_q     <= hs_in_i;
            hs_s2_q     <= hs_s1_q;
            vs_s1_q     <= vs_in_i;
            vs_s2_q     <= vs_s1_q;
            rgb_q       <= rgb_d;
            de_out_q    <= de_s2_q;
            hs_out_q    <= hs_s2_q;
            vs_out_q    <= vs_s2_q;
        end
    end

    assign rom_addr_o = rom_addr_q;
    assign rgb_out_o  = rgb_q;
    assign de_out_o   = de_out_q;
    assign hs_out_o   = hs_out_q;
    assign vs_out_o   = vs_out_q;

endmodule

// File: tb/tb_method_sprite_blit.sv
// Self-checking bench for method_sprite_blit: scoreboard of expected pixels/syncs against a ROM model.
`timescale 1ns/1ps
module tb_method_sprite_blit;

    logic        clk = 1'b0;
    logic        rst_n, frame_start, de_in, hs_in, vs_in, spr_show;
    logic [9:0]  pix_x, pix_y, spr_x, spr_y;
    logic [15:0] bg_rgb, rom_data, rgb_out;
    logic [12:0] rom_addr;
    logic        de_out, hs_out, vs_out;
    logic [15:0] rom_mem [0:8191];

    typedef struct {
        logic [15:0] rgb;
        logic [2:0]  sync;
        int          key;
    } exp_t;

    typedef struct {
        logic [15:0] e_rgb;
        logic [15:0] o_rgb;
        logic [2:0]  e_sync;
        logic [2:0]  o_sync;
        int          key;
    } pair_t;

    exp_t        sb[$];
    pair_t       done_q[$];
    logic [15:0] cap [int];
    logic [9:0]  m_px, m_py;
    logic        m_show;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    method_sprite_blit dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .frame_start_i(frame_start),
        .pix_x_i      (pix_x),
        .pix_y_i      (pix_y),
        .de_in_i      (de_in),
        .hs_in_i      (hs_in),
        .vs_in_i      (vs_in),
        .bg_rgb_i     (bg_rgb),
        .spr_x_i      (spr_x),
        .spr_y_i      (spr_y),
        .spr_show_i   (spr_show),
        .rom_addr_o   (rom_addr),
        .rom_data_i   (rom_data),
        .rgb_out_o    (rgb_out),
        .de_out_o     (de_out),
        .hs_out_o     (hs_out),
        .vs_out_o     (vs_out)
    );

    function automatic logic [15:0] bg_of(input int x, input int y);
        return {x[7:0], y[7:0]} ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] exp_rgb(input int x, input int y, input logic de, input logic [15:0] bg);
        int dx;
        int dy;
        logic [15:0] d;
        dx = x - int'(m_px);
        dy = y - int'(m_py);
        if (m_show && de && dx >= 0 && dx < 90 && dy >= 0 && dy < 90) begin
            d = rom_mem[dy * 90 + dx];
`ifdef METHOD_SPRITE_KEY_EN
            if (d == 16'hF81F) return bg;
`endif
            return d;
        end
        return bg;
    endfunction

    function automatic logic [15:0] get_cap(input int x, input int y);
        if (cap.exists(y * 1024 + x)) return cap[y * 1024 + x];
        return 16'hxxxx;
    endfunction

    // One pixel clock: drive, push expectation, collect the output that is due now.
    task automatic step(input logic fs, input logic de, input logic hs, input logic vs,
                        input int x, input int y, input logic [15:0] bg);
        exp_t  e;
        pair_t p;
        frame_start = fs;
        de_in       = de;
        hs_in       = hs;
        vs_in       = vs;
        pix_x       = x[9:0];
        pix_y       = y[9:0];
        bg_rgb      = bg;
        @(posedge clk);
        e.rgb  = exp_rgb(x, y, de, bg);
        e.sync = {de, hs, vs};
        e.key  = de ? (y * 1024 + x) : -1;
        sb.push_back(e);
        if (fs) begin
            m_px   = spr_x;
            m_py   = spr_y;
            m_show = spr_show;
        end
        #1;
        if (sb.size() == 3) begin
            e        = sb.pop_front();
            p.e_rgb  = e.rgb;
            p.o_rgb  = rgb_out;
            p.e_sync = e.sync;
            p.o_sync = {de_out, hs_out, vs_out};
            p.key    = e.key;
            done_q.push_back(p);
            if (e.key >= 0) cap[e.key] = rgb_out;
        end
    endtask

    task automatic scan(input int sx, input int sy, input logic show, input int x0, input int x1,
                        input int y0, input int y1, input int chg_y, input int chg_x);
        spr_x    = sx[9:0];
        spr_y    = sy[9:0];
        spr_show = show;
        step(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 16'h0000);
        step(1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 16'h0000);
        for (int y = y0; y <= y1; y++) begin
            if (y == chg_y) spr_x = chg_x[9:0];
            for (int x = x0; x <= x1; x++) step(1'b0, 1'b1, 1'b0, 1'b0, x, y, bg_of(x, y));
            step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 16'h0000);
            step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 16'h0000);
            step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 16'h0000);
        end
    endtask

    task automatic test_reset();
        pair_t p;
        rst_n = 1'b0;
        de_in = 1'b1;
        bg_rgb = 16'h1234;
        for (int i = 0; i < 6; i++) begin
            pix_x = 10'(100 + i);
            pix_y = 10'd50;
            hs_in = i[0];
            vs_in = i[1];
            @(posedge clk);
            #1;
            checks++;
            if ({rgb_out, de_out, hs_out, vs_out, rom_addr} !== 32'h0000_0000) begin
                errors++;
                $display("FAIL reset_outputs rgb=%h de=%b hs=%b vs=%b addr=%0d expected all zero",
                         rgb_out, de_out, hs_out, vs_out, rom_addr);
            end
        end
        rst_n  = 1'b1;
        m_px   = 10'd0;
        m_py   = 10'd0;
        m_show = 1'b0;
        sb.delete();
        done_q.delete();
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, i[0], 1'b0, 100 + i, 50, 16'(16'h1234 + i));
        while (done_q.size() > 0) begin
            p = done_q.pop_front();
            checks++;
            if (p.o_rgb !== p.e_rgb || p.o_sync !== p.e_sync) begin
                errors++;
                $display("FAIL reset_bg rgb=%h sync=%b expected rgb=%h sync=%b", p.o_rgb, p.o_sync, p.e_rgb, p.e_sync);
            end
        end
    endtask

    task automatic test_basic();
        pair_t p;
        cap.delete();
        scan(100, 50, 1'b1, 98, 191, 49, 141, -1, 0);
        while (done_q.size() > 0) begin
            p = done_q.pop_front();
            checks++;
            if (p.o_rgb !== p.e_rgb || p.o_sync !== p.e_sync) begin
                errors++;
                $display("FAIL basic_pix key=%0d rgb=%h sync=%b expected rgb=%h sync=%b",
                         p.key, p.o_rgb, p.o_sync, p.e_rgb, p.e_sync);
            end
        end
        checks++;
        if (get_cap(100, 50) !== 16'h0000) begin errors++; $display("FAIL basic_100_50 got %h expected 0000", get_cap(100, 50)); end
        checks++;
        if (get_cap(189, 50) !== 16'd89) begin errors++; $display("FAIL basic_189_50 got %0d expected 89", get_cap(189, 50)); end
        checks++;
        if (get_cap(100, 51) !== 16'd90) begin errors++; $display("FAIL basic_100_51 got %0d expected 90", get_cap(100, 51)); end
        checks++;
        if (get_cap(189, 139) !== 16'd8099) begin errors++; $display("FAIL basic_189_139 got %0d expected 8099", get_cap(189, 139)); end
        checks++;
        if (get_cap(99, 50) !== bg_of(99, 50)) begin errors++; $display("FAIL basic_99_50 got %h expected %h", get_cap(99, 50), bg_of(99, 50)); end
        checks++;
        if (get_cap(190, 50) !== bg_of(190, 50)) begin errors++; $display("FAIL basic_190_50 got %h expected %h", get_cap(190, 50), bg_of(190, 50)); end
        checks++;
        if (get_cap(150, 140) !== bg_of(150, 140)) begin errors++; $display("FAIL basic_below got %h expected %h", get_cap(150, 140), bg_of(150, 140)); end
    endtask

    task automatic test_clip();
        pair_t p;
        cap.delete();
        scan(600, 10, 1'b1, 596, 639, 9, 12, -1, 0);
        while (done_q.size() > 0) begin
            p = done_q.pop_front();
            checks++;
            if (p.o_rgb !== p.e_rgb || p.o_sync !== p.e_sync) begin
                errors++;
                $display("FAIL clip_pix key=%0d rgb=%h sync=%b expected rgb=%h sync=%b",
                         p.key, p.o_rgb, p.o_sync, p.e_rgb, p.e_sync);
            end
        end
        checks++;
        if (get_cap(639, 10) !== 16'd39) begin errors++; $display("FAIL clip_639 got %0d expected 39", get_cap(639, 10)); end
        checks++;
        if (get_cap(600, 11) !== 16'd90) begin errors++; $display("FAIL clip_600_next got %0d expected 90", get_cap(600, 11)); end
        checks++;
        if (get_cap(600, 12) !== 16'd180) begin errors++; $display("FAIL clip_600_row2 got %0d expected 180", get_cap(600, 12)); end
    endtask

    task automatic test_key();
        pair_t p;
        logic [15:0] want;
        cap.delete();
        rom_mem[5] = 16'hF81F;
        scan(100, 50, 1'b1, 103, 107, 50, 50, -1, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 16'h0000);
        while (done_q.size() > 0) begin
            p = done_q.pop_front();
            checks++;
            if (p.o_rgb !== p.e_rgb || p.o_sync !== p.e_sync) begin
                errors++;
                $display("FAIL key_pix key=%0d rgb=%h sync=%b expected rgb=%h sync=%b",
                         p.key, p.o_rgb, p.o_sync, p.e_rgb, p.e_sync);
            end
        end
`ifdef METHOD_SPRITE_KEY_EN
        want = bg_of(105, 50);
`else
        want = 16'hF81F;
`endif
        checks++;
        if (get_cap(105, 50) !== want) begin errors++; $display("FAIL key_105_50 got %h expected %h", get_cap(105, 50), want); end
        checks++;
        if (get_cap(104, 50) !== 16'd4) begin errors++; $display("FAIL key_104_50 got %h expected 0004", get_cap(104, 50)); end
        rom_mem[5] = 16'h0005;
    endtask

    task automatic test_midframe();
        pair_t p;
        cap.delete();
        scan(100, 50, 1'b1, 95, 305, 48, 62, 60, 300);
        checks++;
        if (get_cap(100, 61) !== 16'd990) begin errors++; $display("FAIL mid_old_pos got %0d expected 990", get_cap(100, 61)); end
        checks++;
        if (get_cap(300, 61) !== bg_of(300, 61)) begin errors++; $display("FAIL mid_not_moved got %h expected %h", get_cap(300, 61), bg_of(300, 61)); end
        cap.delete();
        scan(300, 50, 1'b1, 95, 305, 49, 51, -1, 0);
        while (done_q.size() > 0) begin
            p = done_q.pop_front();
            checks++;
            if (p.o_rgb !== p.e_rgb || p.o_sync !== p.e_sync) begin
                errors++;
                $display("FAIL mid_pix key=%0d rgb=%h sync=%b expected rgb=%h sync=%b",
                         p.key, p.o_rgb, p.o_sync, p.e_rgb, p.e_sync);
            end
        end
        checks++;
        if (get_cap(300, 51) !== 16'd90) begin errors++; $display("FAIL mid_new_pos got %0d expected 90", get_cap(300, 51)); end
        checks++;
        if (get_cap(100, 51) !== bg_of(100, 51)) begin errors++; $display("FAIL mid_old_gone got %h expected %h", get_cap(100, 51), bg_of(100, 51)); end
    endtask

    task automatic test_sync();
        pair_t p;
        spr_show = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 16'h0000);
        for (int i = 0; i < 400; i++) begin
            step(1'b0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                 int'($urandom_range(639, 0)), int'($urandom_range(479, 0)), 16'($urandom));
        end
        while (done_q.size() > 0) begin
            p = done_q.pop_front();
            checks++;
            if (p.o_rgb !== p.e_rgb || p.o_sync !== p.e_sync) begin
                errors++;
                $display("FAIL sync_align rgb=%h sync=%b expected rgb=%h sync=%b", p.o_rgb, p.o_sync, p.e_rgb, p.e_sync);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) rom_mem[i] = 16'(i);
        rst_n       = 1'b0;
        frame_start = 1'b0;
        de_in       = 1'b0;
        hs_in       = 1'b0;
        vs_in       = 1'b0;
        pix_x       = 10'd0;
        pix_y       = 10'd0;
        bg_rgb      = 16'h0000;
        spr_x       = 10'd0;
        spr_y       = 10'd0;
        spr_show    = 1'b0;
        m_px        = 10'd0;
        m_py        = 10'd0;
        m_show      = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_clip();
        test_key();
        test_midframe();
        test_sync();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
